// File: rtl/mod_counter_chain.sv
// Cascaded chain of NUM_DIGITS modulo-MOD up/down digit counters.
// Provides sync clear, saturating parallel load, terminal count and wrap/load-error pulses.
module mod_counter_chain #(
    parameter int NUM_DIGITS = 3,
    parameter int MOD        = 10,
    parameter int DW         = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       ena_i,
    input  logic                       up_i,
    input  logic                       clear_i,
    input  logic                       load_i,
    input  logic [NUM_DIGITS*DW-1:0]   load_val_i,
    output logic [NUM_DIGITS*DW-1:0]   q_o,
    output logic [NUM_DIGITS-1:0]      digit_ena_o,
    output logic                       tc_o,
    output logic                       wrap_o,
    output logic                       load_err_o
);

    localparam logic [DW-1:0] MAX_C  = DW'(MOD - 1);
    localparam logic [DW-1:0] ZERO_C = DW'(0);
    localparam logic [DW-1:0] ONE_C  = DW'(1);

    logic [NUM_DIGITS*DW-1:0] q_q, q_d;
    logic                     wrap_q, wrap_d;
    logic                     load_err_q, load_err_d;
    logic [NUM_DIGITS-1:0]    digit_ena_s;
    logic                     tc_s;
    logic [DW-1:0]            end_val_s;

    // One step of a single digit; out-of-range values fold back into range.
    function automatic logic [DW-1:0] step_digit(input logic [DW-1:0] d, input logic dir_up);
        logic [DW-1:0] r;
        r = d;
        if (dir_up) begin
            if (d >= MAX_C) begin
                r = ZERO_C;
            end else begin
                r = d + ONE_C;
            end
        end else begin
            if ((d == ZERO_C) || (d > MAX_C)) begin
                r = MAX_C;
            end else begin
                r = d - ONE_C;
            end
        end
        return r;
    endfunction

    function automatic logic digit_over(input logic [DW-1:0] d);
        return (d > MAX_C);
    endfunction

    // Ripple of step enables through digits sitting at their end value.
    always_comb begin
        end_val_s      = up_i ? MAX_C : ZERO_C;
        digit_ena_s    = '0;
        digit_ena_s[0] = ena_i;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            digit_ena_s[i] = digit_ena_s[i-1] & (q_q[(i-1)*DW +: DW] == end_val_s);
        end
        tc_s = digit_ena_s[NUM_DIGITS-1] & (q_q[(NUM_DIGITS-1)*DW +: DW] == end_val_s);
    end

    // Next-state selection: clear > load > count > hold.
    always_comb begin
        q_d        = q_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        if (clear_i) begin
            q_d = '0;
        end else if (load_i) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (digit_over(load_val_i[i*DW +: DW])) begin
                    q_d[i*DW +: DW] = MAX_C;
                    load_err_d      = 1'b1;
                end else begin
                    q_d[i*DW +: DW] = load_val_i[i*DW +: DW];
                end
            end
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (digit_ena_s[i]) begin
                    q_d[i*DW +: DW] = step_digit(q_q[i*DW +: DW], up_i);
                end else begin
                    q_d[i*DW +: DW] = q_q[i*DW +: DW];
                end
            end
            wrap_d = tc_s;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            q_q        <= '0;
            wrap_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            q_q        <= q_d;
            wrap_q     <= wrap_d;
            load_err_q <= load_err_d;
        end
    end

    assign q_o         = q_q;
    assign digit_ena_o = digit_ena_s;
    assign tc_o        = tc_s;
    assign wrap_o      = wrap_q;
    assign load_err_o  = load_err_q;

endmodule

// File: tb/tb_mod_counter_chain.sv
// Directed and model-compared bench for mod_counter_chain in BCD (3x10) and hex (1x16) builds.
module tb_mod_counter_chain;

    logic        clk = 1'b0;
    logic        reset, ena, up, clear, load;
    logic [11:0] load_val;

    logic [11:0] qa;
    logic [2:0]  dea;
    logic        tca, wrapa, lerra;
    logic [3:0]  qb;
    logic [0:0]  deb;
    logic        tcb, wrapb, lerrb;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    mod_counter_chain #(.NUM_DIGITS(3), .MOD(10), .DW(4)) u_bcd (
        .clk_i(clk), .reset_i(reset), .ena_i(ena), .up_i(up), .clear_i(clear),
        .load_i(load), .load_val_i(load_val), .q_o(qa), .digit_ena_o(dea),
        .tc_o(tca), .wrap_o(wrapa), .load_err_o(lerra)
    );

    mod_counter_chain #(.NUM_DIGITS(1), .MOD(16), .DW(4)) u_hex (
        .clk_i(clk), .reset_i(reset), .ena_i(ena), .up_i(up), .clear_i(clear),
        .load_i(load), .load_val_i(load_val[3:0]), .q_o(qb), .digit_ena_o(deb),
        .tc_o(tcb), .wrap_o(wrapb), .load_err_o(lerrb)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] to_q(input int m, input int md, input int nd);
        logic [11:0] r;
        int v;
        r = 12'h000;
        v = m;
        for (int i = 0; i < nd; i++) begin
            r[i*4 +: 4] = 4'(v % md);
            v = v / md;
        end
        return r;
    endfunction

    function automatic int sat_load(input logic [11:0] lv, input int md, input int nd, output bit err);
        int r, mul, d;
        r = 0; mul = 1; err = 1'b0;
        for (int i = 0; i < nd; i++) begin
            d = int'(lv[i*4 +: 4]);
            if (d >= md) begin
                d = md - 1;
                err = 1'b1;
            end
            r = r + d * mul;
            mul = mul * md;
        end
        return r;
    endfunction

    task automatic test_reset();
        reset = 1'b1; ena = 1'b0; up = 1'b1; clear = 1'b0; load = 1'b0; load_val = 12'h000;
        #3;
        checks++; if (qa !== 12'h000) $display("FAIL reset_q got %h want %h", qa, 12'h000); else passes++;
        checks++; if ({wrapa, lerra, tca} !== 3'b000) $display("FAIL reset_flags got %b want %b", {wrapa, lerra, tca}, 3'b000); else passes++;
        checks++; if (qb !== 4'h0) $display("FAIL reset_qb got %h want %h", qb, 4'h0); else passes++;
        step();
        reset = 1'b0;
    endtask

    task automatic test_async_reset();
        load = 1'b1; load_val = 12'h347;
        step();
        load = 1'b0;
        checks++; if (qa !== 12'h347) $display("FAIL areset_preload got %h want %h", qa, 12'h347); else passes++;
        #2;
        reset = 1'b1;
        #1;
        checks++; if (qa !== 12'h000) $display("FAIL areset_immediate got %h want %h", qa, 12'h000); else passes++;
        ena = 1'b1; up = 1'b1;
        reset = 1'b0;
        step();
        checks++; if (qa !== 12'h001) $display("FAIL areset_first_edge got %h want %h", qa, 12'h001); else passes++;
        for (int i = 0; i < 11; i++) step();
        checks++; if (qa !== 12'h012) $display("FAIL areset_12_edges got %h want %h", qa, 12'h012); else passes++;
    endtask

    task automatic test_up_wrap();
        ena = 1'b0; up = 1'b1; load = 1'b1; load_val = 12'h998;
        step();
        load = 1'b0; ena = 1'b1;
        #1;
        checks++; if (tca !== 1'b0) $display("FAIL upwrap_tc_at_998 got %b want %b", tca, 1'b0); else passes++;
        step();
        checks++; if (qa !== 12'h999) $display("FAIL upwrap_q999 got %h want %h", qa, 12'h999); else passes++;
        checks++; if (tca !== 1'b1) $display("FAIL upwrap_tc got %b want %b", tca, 1'b1); else passes++;
        checks++; if (dea !== 3'b111) $display("FAIL upwrap_digit_ena got %b want %b", dea, 3'b111); else passes++;
        step();
        checks++; if ({qa, wrapa} !== {12'h000, 1'b1}) $display("FAIL upwrap_rollover got q=%h wrap=%b want q=000 wrap=1", qa, wrapa); else passes++;
        step();
        checks++; if ({qa, wrapa} !== {12'h001, 1'b0}) $display("FAIL upwrap_after got q=%h wrap=%b want q=001 wrap=0", qa, wrapa); else passes++;
    endtask

    task automatic test_down_wrap();
        up = 1'b0; ena = 1'b1; load = 1'b1; load_val = 12'h001;
        step();
        load = 1'b0;
        checks++; if (qa !== 12'h001) $display("FAIL down_load got %h want %h", qa, 12'h001); else passes++;
        step();
        checks++; if ({qa, tca} !== {12'h000, 1'b1}) $display("FAIL down_zero got q=%h tc=%b want q=000 tc=1", qa, tca); else passes++;
        step();
        checks++; if ({qa, wrapa} !== {12'h999, 1'b1}) $display("FAIL down_rollover got q=%h wrap=%b want q=999 wrap=1", qa, wrapa); else passes++;
        step();
        checks++; if ({qa, wrapa} !== {12'h998, 1'b0}) $display("FAIL down_after got q=%h wrap=%b want q=998 wrap=0", qa, wrapa); else passes++;
        up = 1'b1;
        #1;
        checks++; if (dea !== 3'b001) $display("FAIL dir_change_digit_ena got %b want %b", dea, 3'b001); else passes++;
        step();
        checks++; if (qa !== 12'h999) $display("FAIL dir_change_q got %h want %h", qa, 12'h999); else passes++;
    endtask

    task automatic test_load_err();
        ena = 1'b0; load = 1'b1; load_val = 12'hAF3;
        step();
        load = 1'b0;
        checks++; if ({qa, lerra} !== {12'h993, 1'b1}) $display("FAIL loaderr_sat got q=%h err=%b want q=993 err=1", qa, lerra); else passes++;
        step();
        checks++; if (lerra !== 1'b0) $display("FAIL loaderr_pulse got %b want %b", lerra, 1'b0); else passes++;
        load = 1'b1; load_val = 12'h123;
        step();
        load = 1'b0;
        checks++; if ({qa, lerra} !== {12'h123, 1'b0}) $display("FAIL loaderr_clean got q=%h err=%b want q=123 err=0", qa, lerra); else passes++;
    endtask

    task automatic test_priority();
        load = 1'b1; load_val = 12'h555;
        step();
        checks++; if (qa !== 12'h555) $display("FAIL prio_preload got %h want %h", qa, 12'h555); else passes++;
        clear = 1'b1; load = 1'b1; ena = 1'b1; up = 1'b1; load_val = 12'h777;
        step();
        clear = 1'b0;
        checks++; if (qa !== 12'h000) $display("FAIL prio_clear got %h want %h", qa, 12'h000); else passes++;
        load_val = 12'h200;
        step();
        load = 1'b0; ena = 1'b0;
        checks++; if (qa !== 12'h200) $display("FAIL prio_load_no_inc got %h want %h", qa, 12'h200); else passes++;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({qa, tca, dea, wrapa} !== {12'h200, 1'b0, 3'b000, 1'b0})
                $display("FAIL hold_cycle%0d got q=%h tc=%b de=%b wrap=%b want q=200 tc=0 de=000 wrap=0", i, qa, tca, dea, wrapa);
            else passes++;
        end
    endtask

    task automatic test_hex_wrap();
        up = 1'b1; ena = 1'b1; load = 1'b1; load_val = 12'h00F;
        step();
        load = 1'b0;
        checks++; if ({qb, tcb} !== {4'hF, 1'b1}) $display("FAIL hex_at_f got q=%h tc=%b want q=f tc=1", qb, tcb); else passes++;
        step();
        checks++; if ({qb, wrapb} !== {4'h0, 1'b1}) $display("FAIL hex_wrap got q=%h wrap=%b want q=0 wrap=1", qb, wrapb); else passes++;
        step();
        checks++; if ({qb, wrapb} !== {4'h1, 1'b0}) $display("FAIL hex_after got q=%h wrap=%b want q=1 wrap=0", qb, wrapb); else passes++;
    endtask

    task automatic test_random();
        int  ma, mb;
        bit  wa, la, wb, lb, tce_a, tce_b, err;
        logic [11:0] expa, expb_full;
        ena = 1'b0; load = 1'b0; clear = 1'b1;
        step();
        clear = 1'b0;
        ma = 0; mb = 0; wa = 1'b0; la = 1'b0; wb = 1'b0; lb = 1'b0;
        for (int c = 0; c < 400; c++) begin
            clear = ($urandom_range(0, 19) == 0);
            load  = ($urandom_range(0, 9) == 0);
            ena   = ($urandom_range(0, 3) != 0);
            up    = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       load_val = 12'h999;
                1:       load_val = 12'h000;
                default: load_val = 12'($urandom_range(0, 4095));
            endcase
            #1;
            tce_a = ena && (up ? (ma == 999) : (ma == 0));
            tce_b = ena && (up ? (mb == 15) : (mb == 0));
            checks++; if (tca !== tce_a) $display("FAIL rand_tc_a cyc%0d got %b want %b", c, tca, tce_a); else passes++;
            checks++; if (tcb !== tce_b) $display("FAIL rand_tc_b cyc%0d got %b want %b", c, tcb, tce_b); else passes++;
            if (clear) begin
                ma = 0; mb = 0; wa = 1'b0; la = 1'b0; wb = 1'b0; lb = 1'b0;
            end else if (load) begin
                ma = sat_load(load_val, 10, 3, err); la = err; wa = 1'b0;
                mb = sat_load(load_val, 16, 1, err); lb = err; wb = 1'b0;
            end else if (ena) begin
                wa = tce_a; wb = tce_b; la = 1'b0; lb = 1'b0;
                ma = up ? ((ma == 999) ? 0 : ma + 1) : ((ma == 0) ? 999 : ma - 1);
                mb = up ? ((mb == 15) ? 0 : mb + 1) : ((mb == 0) ? 15 : mb - 1);
            end else begin
                wa = 1'b0; wb = 1'b0; la = 1'b0; lb = 1'b0;
            end
            step();
            expa = to_q(ma, 10, 3);
            expb_full = to_q(mb, 16, 1);
            checks++;
            if ({qa, wrapa, lerra} !== {expa, wa, la})
                $display("FAIL rand_a cyc%0d got q=%h wrap=%b err=%b want q=%h wrap=%b err=%b", c, qa, wrapa, lerra, expa, wa, la);
            else passes++;
            checks++;
            if ({qb, wrapb, lerrb} !== {expb_full[3:0], wb, lb})
                $display("FAIL rand_b cyc%0d got q=%h wrap=%b err=%b want q=%h wrap=%b err=%b", c, qb, wrapb, lerrb, expb_full[3:0], wb, lb);
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_async_reset();
        test_up_wrap();
        test_down_wrap();
        test_load_err();
        test_priority();
        test_hex_wrap();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mod_counter_chain.md
Name: mod_counter_chain

Overview:
Parametrised successor to the single-digit decade counter. It is a chain of NUM_DIGITS cascaded modulo-MOD digit counters with enable, up/down direction, synchronous clear, parallel load and terminal-count/carry outputs. It is intended as a shared timebase/BCD counter for display, timer and stimulus blocks. Reset is asynchronous, unlike the earlier synchronous-reset counter.

Parameters:
NUM_DIGITS, 3, number of cascaded digits (1..8)
MOD, 10, modulus of every digit (2..2**DW)
DW, 4, bits per digit; must satisfy MOD <= 2**DW

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  asynchronous, active-high reset
ena  input  1  count enable for digit 0
up  input  1  direction: 1 = increment, 0 = decrement
clear  input  1  synchronous clear of all digits
load  input  1  synchronous parallel load
load_val  input  NUM_DIGITS*DW  load data; digit i at [i*DW +: DW]
q  output  NUM_DIGITS*DW  counter value; digit i at [i*DW +: DW], digit 0 least significant
digit_ena  output  NUM_DIGITS  combinational per-digit step enable; bit 0 = ena
tc  output  1  combinational terminal count: ena & every digit at its end value
wrap  output  1  registered one-cycle pulse after the full chain wrapped
load_err  output  1  registered one-cycle pulse after a load that contained an out-of-range digit

Behaviour:
- Reset (async, any time): q = 0, wrap = 0, load_err = 0, effective immediately and independent of clk. On release, counting resumes on the first rising edge where ena = 1.
- Per-edge priority: clear > load > count > hold.
- clear = 1: all digits set to 0; wrap = 0; load_err = 0.
- load = 1 (clear = 0): digit i takes load_val digit i. Any digit >= MOD is saturated to MOD-1, and load_err pulses 1 on the next cycle. wrap = 0. Load ignores ena and up.
- Count (clear = 0, load = 0):
  - End value: MOD-1 when up = 1, 0 when up = 0.
  - digit_ena[0] = ena; digit_ena[i] = digit_ena[i-1] & (digit i-1 == end value).
  - A digit with digit_ena = 1 steps by +1 or -1. Up: MOD-1 -> 0. Down: 0 -> MOD-1.
- tc = digit_ena[NUM_DIGITS-1] & (top digit == end value), i.e. ena with all digits at the end value.
- wrap <= tc on counted edges, so it is high for exactly the cycle after the chain rolls over (999->000 up, 000->999 down).
- ena = 0: q holds; digit_ena = 0; tc = 0; wrap = 0 next cycle.
- Direction may change on any cycle. The next step uses the new up value, with no pipeline delay.
- digit_ena and tc are combinational from q, ena and up; no registered lag.
- Latency: q updates one edge after the controlling input is sampled.
- Out-of-range state: unreachable in normal operation. If reached via X or upset, the next increment forces that digit to 0.
- Outputs never show X after reset.

Test Plan:
- Assert reset mid-count at q=0x347, with no clk edge -> q=0x000 immediately. Hold ena=1 and release reset -> q=0x001 after 1 edge and 0x012 after 12 edges.
- Load 0x998, up=1, ena=1 -> q sequence 0x999 (tc=1, digit_ena=3'b111), then 0x000 with wrap=1 for exactly one cycle, then 0x001 with wrap=0.
- Load 0x001, up=0, ena=1 -> q sequence 0x000 (tc=1), then 0x999 with wrap=1, then 0x998. Toggle up to 1 at 0x998 -> next q=0x999.
- Load 0xAF3 -> q=0x993 and load_err=1 for one cycle. Load 0x123 -> load_err=0.
- Assert clear, load and ena together with q=0x555 -> q=0x000. Then load and ena with load_val=0x200 -> q=0x200 (no increment). Then ena=0 for 5 cycles -> q holds 0x200, tc=0.
- Random ena/up/clear/load for 400 cycles with MOD=10 and NUM_DIGITS=3, compared against a behavioural model -> zero mismatches. Repeat with MOD=16, DW=4, NUM_DIGITS=1 -> single-digit hex wrap 0xF->0x0 with wrap=1.
